// File: rtl/exec_ctrl_64.sv
// Y86-64 execute-stage controller: operand routing, ALU, CC register and Cnd evaluation.
// Optional build macro: EXEC_OVERFLOW_TRAP_EN (OPq signed overflow reports an error and halts).

module alu_64 (
  input  logic [63:0] aluA,
  input  logic [63:0] aluB,
  input  logic [1:0]  aluFun,
  output logic [63:0] aluResult
);
  always_comb begin
    aluResult = '0;
    case (aluFun)
      2'b00: aluResult = aluA + aluB;
      2'b01: aluResult = aluA - aluB;
      2'b10: aluResult = aluA & aluB;
      2'b11: aluResult = aluA ^ aluB;
      default: aluResult = '0;
    endcase
  end
endmodule

module exec_ctrl_64 #(
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [63:0] in_valA,
  input  logic [63:0] in_valB,
  input  logic [63:0] in_valC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_valE,
  output logic        out_cnd,
  output logic [2:0]  out_cc,
  output logic        out_halt,
  output logic        out_err
);
  localparam int unsigned DataW = 64;

  localparam logic [3:0] IHalt  = 4'h0;
  localparam logic [3:0] ICmov  = 4'h2;
  localparam logic [3:0] IIrmov = 4'h3;
  localparam logic [3:0] IRmmov = 4'h4;
  localparam logic [3:0] IMrmov = 4'h5;
  localparam logic [3:0] IOpq   = 4'h6;
  localparam logic [3:0] IJxx   = 4'h7;
  localparam logic [3:0] ICall  = 4'h8;
  localparam logic [3:0] IRet   = 4'h9;
  localparam logic [3:0] IPush  = 4'hA;
  localparam logic [3:0] IPop   = 4'hB;

  typedef enum logic [1:0] {IDLE, EXEC, DONE, HALT} state_t;

  state_t      state;
  logic [3:0]  icodeQ, ifunQ;
  logic [63:0] valAQ, valBQ, valCQ;
  logic        trapQ;

  logic [63:0] aluA, aluB, aluResult, valENext;
  logic [1:0]  aluFun;
  logic        useAlu, isErr, isOpq, isCond;
  logic        flagZ, flagS, flagO, condTrue, cndNext, trapNext;

  // Operand and function selection per instruction class
  always_comb begin
    aluA   = '0;
    aluB   = '0;
    aluFun = 2'b00;
    useAlu = 1'b0;
    case (icodeQ)
      ICmov:          begin aluA = valAQ; useAlu = 1'b1; end
      IIrmov:         begin aluA = valCQ; useAlu = 1'b1; end
      IRmmov, IMrmov: begin aluA = valBQ; aluB = valCQ; useAlu = 1'b1; end
      IOpq:           begin aluA = valBQ; aluB = valAQ; aluFun = ifunQ[1:0]; useAlu = 1'b1; end
      ICall, IPush:   begin aluA = valBQ; aluB = DataW'(8); aluFun = 2'b01; useAlu = 1'b1; end
      IRet, IPop:     begin aluA = valBQ; aluB = DataW'(8); useAlu = 1'b1; end
      default:        ;
    endcase
  end

  alu_64 uAlu (
    .aluA      (aluA),
    .aluB      (aluB),
    .aluFun    (aluFun),
    .aluResult (aluResult)
  );

  // Error detection, result flags and condition evaluation against the pre-instruction CC
  always_comb begin
    isOpq  = (icodeQ == IOpq);
    isCond = (icodeQ == ICmov) || (icodeQ == IJxx);
    isErr  = (icodeQ > IPop) || (isOpq && (ifunQ > 4'd3)) || (isCond && (ifunQ > 4'd6));
    valENext = (useAlu && !isErr) ? aluResult : '0;

    flagZ = (aluResult == '0);
    flagS = aluResult[63];
    flagO = 1'b0;
    if (aluFun == 2'b00)
      flagO = (aluA[63] == aluB[63]) && (aluResult[63] != aluA[63]);
    else if (aluFun == 2'b01)
      flagO = (aluA[63] != aluB[63]) && (aluResult[63] != aluA[63]);

    condTrue = 1'b0;
    case (ifunQ)
      4'd0: condTrue = 1'b1;
      4'd1: condTrue = (out_cc[1] ^ out_cc[0]) | out_cc[2];
      4'd2: condTrue = out_cc[1] ^ out_cc[0];
      4'd3: condTrue = out_cc[2];
      4'd4: condTrue = !out_cc[2];
      4'd5: condTrue = !(out_cc[1] ^ out_cc[0]);
      4'd6: condTrue = !(out_cc[1] ^ out_cc[0]) && !out_cc[2];
      default: condTrue = 1'b0;
    endcase
    cndNext = isCond && !isErr && condTrue;

`ifdef EXEC_OVERFLOW_TRAP_EN
    trapNext = isOpq && !isErr && flagO;
`else
    trapNext = 1'b0;
`endif
  end

  // Control FSM with registered outputs; CC register lives in out_cc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      icodeQ    <= '0;
      ifunQ     <= '0;
      valAQ     <= '0;
      valBQ     <= '0;
      valCQ     <= '0;
      trapQ     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_cc    <= CC_RESET;
      out_halt  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_icode == IHalt) begin
              state    <= HALT;
              out_halt <= 1'b1;
            end else begin
              state  <= EXEC;
              icodeQ <= in_icode;
              ifunQ  <= in_ifun;
              valAQ  <= in_valA;
              valBQ  <= in_valB;
              valCQ  <= in_valC;
            end
          end
        end
        EXEC: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_valE  <= valENext;
          out_cnd   <= cndNext;
          out_err   <= isErr || trapNext;
          trapQ     <= trapNext;
          if (isOpq && !isErr)
            out_cc <= {flagZ, flagS, flagO};
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (trapQ) begin
              state    <= HALT;
              out_halt <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end
        end
        HALT: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_halt  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_ctrl_64.sv
// Scoreboard bench for exec_ctrl_64: directed Y86-64 cases plus randomized instructions
// checked against an arithmetic reference model of the execute stage.

module tb_exec_ctrl_64;
  localparam logic [2:0] CcReset = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun;
  logic [63:0] in_valA, in_valB, in_valC;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_valE;
  logic        out_cnd;
  logic [2:0]  out_cc;
  logic        out_halt;
  logic        out_err;

  exec_ctrl_64 #(.CC_RESET(CcReset)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_icode  (in_icode),
    .in_ifun   (in_ifun),
    .in_valA   (in_valA),
    .in_valB   (in_valB),
    .in_valC   (in_valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_valE  (out_valE),
    .out_cnd   (out_cnd),
    .out_cc    (out_cc),
    .out_halt  (out_halt),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  logic [2:0] modelCc;
  int         checks = 0;
  int         errors = 0;
  logic       holdReady;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what execute must produce for one instruction, from the ISA rules
  function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t        e;
    logic [63:0] r;
    logic [64:0] wide;
    logic        bad, ovf, zf, lt;
    zf  = modelCc[2];
    lt  = (modelCc[1] != modelCc[0]);
    bad = (ic > 4'd11) || (ic == 4'd6 && fn > 4'd3) || ((ic == 4'd2 || ic == 4'd7) && fn > 4'd6);
    r   = '0;
    ovf = 1'b0;
    e   = '0;
    if (!bad) begin
      case (ic)
        4'd2, 4'd7: begin
          case (fn)
            4'd0: e.cnd = 1'b1;
            4'd1: e.cnd = lt || zf;
            4'd2: e.cnd = lt;
            4'd3: e.cnd = zf;
            4'd4: e.cnd = !zf;
            4'd5: e.cnd = !lt;
            default: e.cnd = !lt && !zf;
          endcase
          r = (ic == 4'd2) ? a : 64'd0;
        end
        4'd3:       r = c;
        4'd4, 4'd5: r = b + c;
        4'd6: begin
          case (fn)
            4'd0: begin r = b + a; wide = {b[63], b} + {a[63], a}; ovf = (wide != {r[63], r}); end
            4'd1: begin r = b - a; wide = {b[63], b} - {a[63], a}; ovf = (wide != {r[63], r}); end
            4'd2: r = b & a;
            default: r = b ^ a;
          endcase
          modelCc = {r == 64'd0, r[63], ovf};
        end
        4'd8, 4'd10: r = b - 64'd8;
        4'd9, 4'd11: r = b + 64'd8;
        default:     r = '0;
      endcase
    end
    e.valE = r;
    e.cc   = modelCc;
    e.err  = bad;
`ifdef EXEC_OVERFLOW_TRAP_EN
    if (ovf) e.err = 1'b1;
`endif
    return e;
  endfunction

  // Present one instruction; expectation is queued once the handshake edge has passed
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_icode = ic; in_ifun = fn; in_valA = a; in_valB = b; in_valC = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_valA = $urandom; in_valB = $urandom; in_valC = $urandom;
    if (ic != 4'd0) begin
      sbq.push_back(model(ic, fn, a, b, c));
      chk("exec_not_valid", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || !in_ready) chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Monitor: compare each result as it is taken by downstream
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("valE", out_valE, e.valE);
          chk("cnd", 64'(out_cnd), 64'(e.cnd));
          chk("cc", 64'(out_cc), 64'(e.cc));
          chk("err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  // Downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!holdReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [63:0] snapE;
    logic [3:0]  ic, fn;
    logic [63:0] a, b;
    holdReady = 1'b1;
    out_ready = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0;
    in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
    modelCc = CcReset;
    #12;
    chk("rst_cc", 64'(out_cc), 64'(CcReset));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_valE", out_valE, 64'd0);
    chk("rst_halt_err", {62'd0, out_halt, out_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    holdReady = 1'b0;

    issue(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);          // subq: 3-5
    issue(4'h7, 4'h1, 64'd0, 64'd0, 64'h40);         // jle on CC=010
    issue(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);         // je on CC=010
    issue(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0);       // cmovl
    issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);        // pushq
    drain();

    holdReady = 1'b1;
    out_ready = 1'b0;
    issue(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);        // popq under stall
    wait_valid();
    snapE = out_valE;
    chk("popq_valE", out_valE, 64'h108);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valE", out_valE, snapE);
      chk("stall_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
    end
    holdReady = 1'b0;

`ifndef EXEC_OVERFLOW_TRAP_EN
    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
`endif
    issue(4'hC, 4'h0, 64'd1, 64'd2, 64'd3);          // invalid icode
    issue(4'h6, 4'h5, 64'd1, 64'd2, 64'd3);          // invalid OPq ifun
    issue(4'h6, 4'h1, 64'd9, 64'd9, 64'd0);          // zero result

    for (int i = 0; i < 200; i++) begin
      ic = 4'($urandom_range(1, 12));
      fn = 4'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
`ifdef EXEC_OVERFLOW_TRAP_EN
      if (ic == 4'h6) begin a = 64'(a[31:0]); b = 64'(b[31:0]); end
`endif
      issue(ic, fn, a, b, {$urandom, $urandom});
    end
    drain();

    // Reset while a result is held in DONE
    holdReady = 1'b1;
    out_ready = 1'b0;
    issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
    wait_valid();
    rst_n = 1'b0;
    #1;
    sbq.delete();
    modelCc = CcReset;
    chk("done_rst_cc", 64'(out_cc), 64'(CcReset));
    chk("done_rst_in_ready", 64'(in_ready), 64'd1);
    chk("done_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    holdReady = 1'b0;

`ifdef EXEC_OVERFLOW_TRAP_EN
    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    for (int n = 0; n < 40 && !out_halt; n++) @(negedge clk);
`else
    issue(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
`endif
    chk("halt", 64'(out_halt), 64'd1);
    chk("halt_in_ready", 64'(in_ready), 64'd0);

    in_icode = 4'h3; in_ifun = 4'h0; in_valC = 64'h77;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_ignores_input", {61'd0, out_valid, in_ready, out_halt}, 64'd1);
    end
    in_valid = 1'b0;
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
